// File: rtl/pwm_motor_driver_if.sv
// Bundle between the steering logic and the PWM motor driver: per-channel duty and
// direction requests in, bridge enables, direction pins and status back out.
interface pwm_motor_driver_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 20
);
  logic [CHANNELS*CNT_W-1:0] duty_cmd;
  logic [CHANNELS-1:0]       dir_cmd;
  logic                      stop;
  logic [CHANNELS-1:0]       en;
  logic [2*CHANNELS-1:0]     in;
  logic                      period_tick;
  logic [CHANNELS*CNT_W-1:0] duty_applied;

  modport master (
    output duty_cmd, dir_cmd, stop,
    input  en, in, period_tick, duty_applied
  );

  modport slave (
    input  duty_cmd, dir_cmd, stop,
    output en, in, period_tick, duty_applied
  );
endinterface

// File: rtl/pwm_motor_driver.sv
// Multi-channel H-bridge PWM driver: shared period counter, per-period duty slew
// limiting, and a ramp-down / dead-time sequence around every direction reversal.
module pwm_motor_driver #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 20,
  parameter int PERIOD       = 250000,
  parameter int RAMP_STEP    = 2500,
  parameter int DEAD_PERIODS = 2
) (
  input logic            clk,
  input logic            rst,
  pwm_motor_driver_if.slave bus
);

  localparam logic [CNT_W-1:0]        LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]        FULL = CNT_W'(PERIOD);
  localparam logic signed [CNT_W+1:0] STEP = (CNT_W + 2)'(RAMP_STEP);
  localparam int                      DC_W = $clog2(DEAD_PERIODS + 1);
  localparam logic [DC_W-1:0]         DEAD_LOAD = DC_W'(DEAD_PERIODS);

  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} state_t;

  function automatic logic [CNT_W-1:0] sat_target(input logic [CNT_W-1:0] d);
    return (d > FULL) ? FULL : d;
  endfunction

  // One slew step of at most RAMP_STEP toward t; t >= 0 also keeps the result from underflowing.
  function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] t);
    logic signed [CNT_W+1:0] sa;
    logic signed [CNT_W+1:0] st;
    logic signed [CNT_W+1:0] nxt;
    sa  = $signed({2'b00, a});
    st  = $signed({2'b00, t});
    nxt = sa;
    if (sa < st) begin
      nxt = sa + STEP;
      if (nxt > st) nxt = st;
    end else if (sa > st) begin
      nxt = sa - STEP;
      if (nxt < st) nxt = st;
    end
    return CNT_W'(nxt);
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_p0;
  logic             boundary;

  assign cnt_nxt  = (cnt_p0 == LAST) ? '0 : cnt_p0 + 1'b1;
  assign boundary = (cnt_p0 == LAST);

  // Stage p0: shared period counter and its registered last-count pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= '0;
      tick_p0 <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nxt;
      tick_p0 <= (cnt_nxt == LAST);
    end
  end

  assign bus.period_tick = tick_p0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_p0;
    state_t           st_dir;
    state_t           state_nxt;
    logic             dir_p0;
    logic             dir_req;
    logic [DC_W-1:0]  dead_p0;
    logic [CNT_W-1:0] duty_p0;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] duty_ramp;
    logic             en_p1;
    logic [1:0]       pins;

    assign dir_req = bus.dir_cmd[i];

    // Direction-driven transitions resolve first so the boundary update sees the new target.
    always_comb begin
      st_dir = state_p0;
      case (state_p0)
        RUN:       if (dir_req != dir_p0) st_dir = RAMP_DOWN;
        RAMP_DOWN: if (dir_req == dir_p0) st_dir = RUN;
        DEAD:      if (boundary && dead_p0 == DC_W'(1)) st_dir = RUN;
        default:   st_dir = RUN;
      endcase
      tgt       = (st_dir == RUN) ? sat_target(bus.duty_cmd[i*CNT_W +: CNT_W]) : '0;
      duty_ramp = boundary ? ramp(duty_p0, tgt) : duty_p0;
      state_nxt = st_dir;
      if (st_dir == RAMP_DOWN && (bus.stop || (boundary && duty_ramp == '0)))
        state_nxt = DEAD;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_p0 <= RUN;
        dir_p0   <= 1'b1;
        dead_p0  <= '0;
      end else begin
        state_p0 <= state_nxt;
        if (state_p0 == DEAD && st_dir == RUN) dir_p0 <= dir_req;
        if (state_nxt == DEAD && state_p0 != DEAD) dead_p0 <= DEAD_LOAD;
        else if (state_p0 == DEAD && boundary)     dead_p0 <= dead_p0 - DC_W'(1);
      end
    end

    // Stage p1: applied duty and compare-registered enable; stop overrides the slew rule
    always_ff @(posedge clk) begin
      if (rst || bus.stop) begin
        duty_p0 <= '0;
        en_p1   <= 1'b0;
      end else begin
        duty_p0 <= duty_ramp;
        en_p1   <= (cnt_p0 < duty_p0);
      end
    end

    always_comb begin
      pins = 2'b00;
      if (state_p0 != DEAD) pins = dir_p0 ? 2'b10 : 2'b01;
    end

    assign bus.en[i]                           = en_p1;
    assign bus.in[2*i +: 2]                    = pins;
    assign bus.duty_applied[i*CNT_W +: CNT_W]  = duty_p0;
  end

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Directed bench for pwm_motor_driver: per-period vector table plus hand sequences
// for emergency stop, stop-forced dead time and mid-period reset.
module tb_pwm_motor_driver;
  localparam int CH = 2, W = 8, P = 100, STEP = 25, DP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_motor_driver_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

  pwm_motor_driver #(.CHANNELS(CH), .CNT_W(W), .PERIOD(P), .RAMP_STEP(STEP),
                     .DEAD_PERIODS(DP)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d0, d1;
    logic [1:0] dir;
    int         a0, a1, hi0, hi1;
    logic [3:0] pins;
    int         coast0;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int d0, input int d1, input logic [1:0] dir);
    bus.duty_cmd = {W'(d1), W'(d0)};
    bus.dir_cmd  = dir;
  endtask

  task automatic to_boundary(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < P + 2; k++) begin
      @(posedge clk); #1;
      if (bus.period_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic period_step(output int hi0, output int hi1, output int ticks,
                             output int coast0, output int bad);
    hi0 = 0; hi1 = 0; ticks = 0; coast0 = 0; bad = 0;
    for (int k = 0; k < P; k++) begin
      @(posedge clk); #1;
      hi0   += int'(bus.en[0]);
      hi1   += int'(bus.en[1]);
      ticks += int'(bus.period_tick);
      if (bus.in[1:0] == 2'b00) begin
        coast0++;
        if (bus.en[0]) bad++;
      end
    end
  endtask

  initial begin
    bit ok;
    int hi0, hi1, ticks, coast0, bad, n;

    //          d0  d1   dir    a0  a1  hi0 hi1  pins     coast0
    tbl[0]  = '{60,   0, 2'b11, 25,   0,  0,   0, 4'b1010,   0};
    tbl[1]  = '{60,   0, 2'b11, 50,   0, 25,   0, 4'b1010,   0};
    tbl[2]  = '{60,   0, 2'b11, 60,   0, 50,   0, 4'b1010,   0};
    tbl[3]  = '{60,   0, 2'b11, 60,   0, 60,   0, 4'b1010,   0};
    tbl[4]  = '{60, 255, 2'b11, 60,  25, 60,   0, 4'b1010,   0};
    tbl[5]  = '{60, 255, 2'b11, 60,  50, 60,  25, 4'b1010,   0};
    tbl[6]  = '{60, 255, 2'b11, 60,  75, 60,  50, 4'b1010,   0};
    tbl[7]  = '{60, 255, 2'b11, 60, 100, 60,  75, 4'b1010,   0};
    tbl[8]  = '{60, 255, 2'b11, 60, 100, 60, 100, 4'b1010,   0};
    tbl[9]  = '{60,   0, 2'b11, 60,  75, 60, 100, 4'b1010,   0};
    tbl[10] = '{60,   0, 2'b11, 60,  50, 60,  75, 4'b1010,   0};
    tbl[11] = '{60,   0, 2'b11, 60,  25, 60,  50, 4'b1010,   0};
    tbl[12] = '{60,   0, 2'b11, 60,   0, 60,  25, 4'b1010,   0};
    tbl[13] = '{60,   0, 2'b11, 60,   0, 60,   0, 4'b1010,   0};
    tbl[14] = '{60,   0, 2'b10, 35,   0, 60,   0, 4'b1010,   0};
    tbl[15] = '{60,   0, 2'b10, 10,   0, 35,   0, 4'b1010,   0};
    tbl[16] = '{60,   0, 2'b10,  0,   0, 10,   0, 4'b1000,   1};
    tbl[17] = '{60,   0, 2'b10,  0,   0,  0,   0, 4'b1000, 100};
    tbl[18] = '{60,   0, 2'b10, 25,   0,  0,   0, 4'b1001,  99};
    tbl[19] = '{60,  60, 2'b10, 50,  25, 25,   0, 4'b1001,   0};
    tbl[20] = '{60,  60, 2'b10, 60,  50, 50,  25, 4'b1001,   0};
    tbl[21] = '{60,  60, 2'b10, 60,  60, 60,  50, 4'b1001,   0};
    tbl[22] = '{60,  60, 2'b11, 35,  60, 60,  60, 4'b1001,   0};
    tbl[23] = '{60,  60, 2'b10, 60,  60, 35,  60, 4'b1001,   0};
    tbl[24] = '{60,  60, 2'b10, 60,  60, 60,  60, 4'b1001,   0};

    bus.duty_cmd = '0;
    bus.dir_cmd  = 2'b11;
    bus.stop     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_en", bus.en, 0);
    check("reset_tick", bus.period_tick, 0);
    check("reset_duty", bus.duty_applied, 0);
    check("reset_in", bus.in, 4'b1010);
    rst = 1'b0;

    to_boundary(ok);
    check("align_first", ok, 1);

    for (int r = 0; r < 25; r++) begin
      drive(tbl[r].d0, tbl[r].d1, tbl[r].dir);
      period_step(hi0, hi1, ticks, coast0, bad);
      check($sformatf("r%0d_a0", r), bus.duty_applied[W-1:0], tbl[r].a0);
      check($sformatf("r%0d_a1", r), bus.duty_applied[2*W-1:W], tbl[r].a1);
      check($sformatf("r%0d_hi0", r), hi0, tbl[r].hi0);
      check($sformatf("r%0d_hi1", r), hi1, tbl[r].hi1);
      check($sformatf("r%0d_in", r), bus.in, tbl[r].pins);
      check($sformatf("r%0d_coast0", r), coast0, tbl[r].coast0);
      check($sformatf("r%0d_ticks", r), ticks, 1);
      check($sformatf("r%0d_en_in_coast", r), bad, 0);
    end

    // Emergency stop mid-period with both channels at 60
    repeat (30) @(posedge clk);
    #1;
    check("pre_stop_en", bus.en, 2'b11);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    check("stop_en", bus.en, 0);
    check("stop_duty", bus.duty_applied, 0);
    check("stop_in", bus.in, 4'b1001);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      n += int'(bus.en[0]) + int'(bus.en[1]);
    end
    check("stop_hold_en", n, 0);
    bus.stop = 1'b0;
    to_boundary(ok);
    check("align_stop1", ok, 1);
    check("restart_a0_25", bus.duty_applied[W-1:0], 25);
    check("restart_a1_25", bus.duty_applied[2*W-1:W], 25);
    to_boundary(ok);
    check("align_stop2", ok, 1);
    check("restart_a0_50", bus.duty_applied[W-1:0], 50);
    check("restart_a1_50", bus.duty_applied[2*W-1:W], 50);

    // Reversal request followed by stop: ramp-down collapses straight into dead time
    bus.dir_cmd = 2'b11;
    @(posedge clk); #1;
    check("rampdown_in_old_dir", bus.in, 4'b1001);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("stop_dead_in", bus.in, 4'b1000);
    check("stop_dead_duty", bus.duty_applied, 0);
    to_boundary(ok);
    check("align_dead", ok, 1);
    check("dead_after_tick_in", bus.in, 4'b1000);
    repeat (50) @(posedge clk);
    #1;
    check("dead_mid_in", bus.in, 4'b1000);
    check("pre_reset_a1", bus.duty_applied[2*W-1:W], 25);

    // Reset at counter 50 while channel 0 is coasting
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_en", bus.en, 0);
    check("rst_mid_tick", bus.period_tick, 0);
    check("rst_mid_duty", bus.duty_applied, 0);
    check("rst_mid_in", bus.in, 4'b1010);
    n = 0;
    for (int k = 0; k < 2 * P; k++) begin
      @(posedge clk); #1;
      n++;
      if (bus.period_tick) break;
    end
    check("rst_tick_spacing", n, P - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_motor_driver.md
Name: pwm_motor_driver

Overview:
Multi-channel, parametrised PWM generator for the H-bridge motor driver enables (ena/enb style) and direction pins (in).
- Shares one free-running period counter across all channels.
- Per channel: accepts a target duty and a direction.
- Slew-limits the applied duty once per period (soft start/stop).
- Enforces ramp-down plus dead time before any direction reversal.
- Sits between the steering logic and the motor driver pins.

Parameters:
CHANNELS, 2, number of motor channels.
CNT_W, 20, counter and duty width in bits.
PERIOD, 250000, PWM period in clk cycles; must satisfy PERIOD < 2^CNT_W.
RAMP_STEP, 2500, maximum change of applied duty per period, in counts; must be at least 1.
DEAD_PERIODS, 2, whole periods the bridge is held in coast during a reversal; must be at least 1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
duty_cmd  in  CHANNELS*CNT_W  target duty per channel; channel i occupies bits [i*CNT_W +: CNT_W].
dir_cmd  in  CHANNELS  requested direction per channel; 1 = forward, 0 = reverse.
stop  in  1  emergency stop; applies to all channels.
en  out  CHANNELS  registered PWM enable per channel.
in  out  2*CHANNELS  bridge direction pins; channel i occupies bits [2i+1:2i].
period_tick  out  1  one-cycle pulse on the last count of each period.
duty_applied  out  CHANNELS*CNT_W  current slew-limited duty per channel; same packing as duty_cmd.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: counter=0, en=0, period_tick=0, duty_applied=0. Every channel goes to RUN with dir latched forward, so in=2'b10.
- Counter:
  - Counts 0..PERIOD-1, then wraps to 0.
  - period_tick is registered and is 1 exactly in the cycle the counter equals PERIOD-1.
- Target clamp: targets above PERIOD are clamped to PERIOD.
- Period boundary (counter == PERIOD-1), per channel, with A = applied duty and T = effective target:
  - If A < T: A <= min(A + RAMP_STEP, T).
  - If A > T: A <= max(A - RAMP_STEP, T), saturating at 0 (no underflow).
  - A never changes at any other counter value.
- Enable output:
  - en[i] <= (counter < A_i), registered, so one cycle of latency from the counter.
  - A = 0 gives en always 0; A = PERIOD gives en always 1.
- Per-channel FSM, states RUN, RAMP_DOWN, DEAD:
  - RUN: T = clamped duty_cmd; in = 10 if the latched dir is 1, else 01. If dir_cmd differs from the latched dir, go to RAMP_DOWN.
  - RAMP_DOWN: T = 0; in still reflects the latched (old) dir. When a boundary update yields A = 0, go to DEAD and load dead_cnt = DEAD_PERIODS. If dir_cmd returns to the latched dir, go back to RUN with no dead time.
  - DEAD: in = 00 (coast), T = 0; dead_cnt decrements on each period_tick. When a tick arrives with dead_cnt = 1, latch dir <= dir_cmd and go to RUN. Ramp-up restarts from 0.
  - Changes of dir_cmd while in DEAD take effect only at exit; the value sampled at the exit tick is the one latched.
- Stop:
  - While stop=1, the next clock forces A=0 and en=0 on all channels, outside the boundary rule.
  - Channels in RAMP_DOWN go to DEAD; RUN and DEAD channels keep their state, and the dead counter keeps running.
  - After stop falls, ramp-up starts from 0 at the following boundaries.
- Reset mid-operation: outputs return to the reset values at the next clock regardless of state or counter value.
- Simultaneous events at one boundary: stop beats the ramp; a direction change and a boundary in the same cycle resolve as state transition first, then the update uses the new T.

Test Plan (CHANNELS=2, CNT_W=8, PERIOD=100, RAMP_STEP=25, DEAD_PERIODS=2):
- Reset, then duty_cmd ch0=60, dir=1 -> A0 steps 0, 25, 50, 60, 60 at successive boundaries; en[0] is high for exactly A0 cycles per period with 1-cycle latency; in[1:0]=10.
- duty_cmd ch1=255 -> A1 clamps at 100 after 4 periods and en[1] stays continuously high; then duty_cmd=0 -> A1 steps 75, 50, 25, 0.
- Ch0 at A=60, dir_cmd flips to 0 -> A0 goes 35, 10, 0; then in[1:0]=00 for 2 full periods; then in=01 and ramp 25, 50, 60. en[0] is never high while in=00.
- Flip dir_cmd and restore it before A reaches 0 -> RUN resumes with no DEAD and in never goes to 00.
- Assert stop mid-period with both channels at A=60 -> next clock en=00 and duty_applied=0; release stop -> ramp from 0 in steps of 25.
- Assert rst at counter=50 during DEAD -> next cycle counter=0, en=0, in=10 for each channel, period_tick=0.
